avalon_ram_responder: RTL and testbench
=======================================

AVALON_RAM_RESPONDER -- requirements
Module: avalon_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, word-address width of internal RAM (2^ADDR_BITS x 16-bit words).
REQ-002 SHALL have parameter READ_LATENCY, default 3, cycles from read acceptance to av_readdatavalid (legal 1..8).
REQ-003 SHALL have parameter MAX_PENDING, default 4, maximum outstanding reads (legal 1..8).
REQ-004 SHALL have parameters REFRESH_PERIOD, default 64, and REFRESH_CYCLES, default 4, stall timing used only under REQ-026.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 sync_reset  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-007 av_address  input  22  word address from initiator.
REQ-008 av_byteenable_n  input  2  active-low byte enables; bit 0 = [7:0], bit 1 = [15:8].
REQ-009 av_chipselect  input  1  transfer qualifier.
REQ-010 av_writedata  input  16  write data.
REQ-011 av_read_n  input  1  active-low read request.
REQ-012 av_write_n  input  1  active-low write request.
REQ-013 av_readdata  output  16  read data, valid when av_readdatavalid=1.
REQ-014 av_readdatavalid  output  1  one-cycle pulse per returned read word.
REQ-015 av_waitrequest  output  1  high = request in this cycle not accepted; initiator holds it.

Function
REQ-016 Request SHALL be accepted in a cycle where av_chipselect=1, (av_read_n=0 or av_write_n=0) and av_waitrequest=0; otherwise ignored.
REQ-017 av_read_n=0 and av_write_n=0 together SHALL be treated as write only; no read data returned.
REQ-018 Accepted write SHALL update only bytes whose av_byteenable_n bit is 0; av_byteenable_n=2'b11 writes nothing.
REQ-019 RAM index SHALL be av_address[ADDR_BITS-1:0]; upper bits ignored (aliasing wrap).
REQ-020 Accepted read SHALL produce av_readdatavalid=1 exactly READ_LATENCY cycles later, in acceptance order, one pulse per read; back-to-back reads yield back-to-back pulses.
REQ-021 Read accepted in the cycle after a write to the same index SHALL return the written data (no stale read).
REQ-022 av_readdata SHALL hold its last value while av_readdatavalid=0.
REQ-023 Pending counter: +1 on read accept, -1 on av_readdatavalid, unchanged when both in same cycle; range 0..MAX_PENDING.
REQ-024 av_waitrequest SHALL be 1 when pending counter = MAX_PENDING, combinationally from registered state only (no path from av_* inputs).
REQ-025 Latency pipeline SHALL be a READ_LATENCY-deep valid shift register plus RAM read register; no read dropped or duplicated.

Reset
REQ-026 While sync_reset=1: av_waitrequest=1, av_readdatavalid=0, av_readdata=0, pending counter=0, latency pipeline cleared, refresh FSM in IDLE with counter 0.
REQ-027 Reset mid-operation SHALL discard all outstanding reads; no av_readdatavalid after reset deasserts for reads accepted before it.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 First cycle after sync_reset falls SHALL have av_waitrequest=0 (unless REQ-024 applies).

Configuration
REQ-030 Macro WAIT_INJECT_EN, when defined, SHALL compile in a refresh-emulation FSM: IDLE counts REFRESH_PERIOD cycles then enters STALL; STALL forces av_waitrequest=1 for REFRESH_CYCLES cycles then returns to IDLE and restarts count.
REQ-031 Under WAIT_INJECT_EN, reads already accepted SHALL complete on schedule during STALL; stall and pending-limit waitrequest are ORed.
REQ-032 Without WAIT_INJECT_EN, FSM and its counter SHALL be absent and av_waitrequest SHALL depend only on REQ-024 and reset.

Verification
REQ-033 Write 0x1234 addr 0x005 be_n=00, then read 0x005 -> readdatavalid 3 cycles after read accept, readdata=0x1234.
REQ-034 Write 0xABCD addr 0x005 be_n=10 over 0x1234, read -> 0x12CD; be_n=11 write -> 0x12CD unchanged.
REQ-035 Read addr 0x0005 and 0x1005 after writing 0x5555 to 0x005 -> both return 0x5555 (aliasing, ADDR_BITS=12).
REQ-036 Issue 6 consecutive reads holding av_read_n=0 -> waitrequest high after 4th accept until first valid; all 6 valids in order, none lost.
REQ-037 Assert sync_reset 1 cycle after 2 reads accepted -> no readdatavalid afterwards; waitrequest=1 during reset, 0 next cycle.
REQ-038 With WAIT_INJECT_EN, idle 64 cycles after reset -> waitrequest=1 for exactly 4 cycles; read held across stall accepted on first cycle after, data correct.

Source files
------------

// File: rtl/avalon_ram_responder.sv
// avalon_ram_responder
//   Avalon-MM slave in front of a 2^ADDR_BITS x 16-bit RAM. Pipelined reads
//   return data READ_LATENCY cycles after acceptance. At most MAX_PENDING
//   reads may be outstanding. Writes are byte-masked.
//
// Optional feature: define WAIT_INJECT_EN to build a refresh-emulation FSM.
//   It raises av_waitrequest for REFRESH_CYCLES cycles after every
//   REFRESH_PERIOD idle cycles.
//
// Ports
//   clk               rising-edge clock
//   sync_reset        synchronous active-high reset (RAM contents are kept)
//   av_address        word address; only the low ADDR_BITS bits index the RAM
//   av_byteenable_n   active-low byte enables (bit0 = [7:0], bit1 = [15:8])
//   av_chipselect     transfer qualifier
//   av_writedata      write data
//   av_read_n         active-low read request
//   av_write_n        active-low write request (wins over a read in the same cycle)
//   av_readdata       read data, held while av_readdatavalid is low
//   av_readdatavalid  one-cycle pulse per returned word
//   av_waitrequest    request in this cycle is not accepted
module avalon_ram_responder #(
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned MAX_PENDING    = 4,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic [21:0] av_address,
  input  logic [1:0]  av_byteenable_n,
  input  logic        av_chipselect,
  input  logic [15:0] av_writedata,
  input  logic        av_read_n,
  input  logic        av_write_n,
  output logic [15:0] av_readdata,
  output logic        av_readdatavalid,
  output logic        av_waitrequest
);

  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  logic [15:0]           mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]  idx;
  logic [PW-1:0]         pending;
  logic [READ_LATENCY-1:0] vpipe;
  logic [15:0]           dpipe [READ_LATENCY];
  logic                  stall;
  logic                  req_ok;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  unused_addr;

  assign idx         = av_address[ADDR_BITS-1:0];
  assign unused_addr = ^av_address[21:ADDR_BITS];

  // Built only from reset and registered state so the initiator's request
  // never loops back into waitrequest.
  assign av_waitrequest = sync_reset | (pending == PW'(MAX_PENDING)) | stall;

  assign req_ok    = av_chipselect & ~av_waitrequest;
  assign wr_accept = req_ok & ~av_write_n;
  assign rd_accept = req_ok & ~av_read_n & av_write_n;

  // RAM array: no reset, contents survive sync_reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (!av_byteenable_n[0]) mem[idx][7:0]  <= av_writedata[7:0];
      if (!av_byteenable_n[1]) mem[idx][15:8] <= av_writedata[15:8];
    end
  end

  // Valid/data pipeline. Stage 0 is the RAM read register. A data stage only
  // loads when a valid word enters it. The last stage therefore also serves as
  // the hold register for av_readdata.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      vpipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dpipe[i] <= '0;
    end else begin
      vpipe[0] <= rd_accept;
      if (rd_accept) dpipe[0] <= mem[idx];
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign av_readdatavalid = vpipe[READ_LATENCY-1] & ~sync_reset;
  assign av_readdata      = sync_reset ? '0 : dpipe[READ_LATENCY-1];

  // Outstanding-read counter
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pending <= '0;
    end else if (rd_accept && !av_readdatavalid) begin
      pending <= pending + PW'(1);
    end else if (!rd_accept && av_readdatavalid) begin
      pending <= pending - PW'(1);
    end
  end

`ifdef WAIT_INJECT_EN
  typedef enum logic {REF_IDLE, REF_STALL} refresh_state_t;

  refresh_state_t rstate;
  logic [15:0]    rcnt;

  // The stall flag is registered and changes together with the state.
  // REF_STALL therefore covers exactly REFRESH_CYCLES cycles of waitrequest.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rstate <= REF_IDLE;
      rcnt   <= '0;
      stall  <= 1'b0;
    end else begin
      case (rstate)
        REF_IDLE: begin
          if (rcnt == 16'(REFRESH_PERIOD - 1)) begin
            rstate <= REF_STALL;
            rcnt   <= '0;
            stall  <= 1'b1;
          end else begin
            rcnt <= rcnt + 16'd1;
          end
        end
        REF_STALL: begin
          if (rcnt == 16'(REFRESH_CYCLES - 1)) begin
            rstate <= REF_IDLE;
            rcnt   <= '0;
            stall  <= 1'b0;
          end else begin
            rcnt <= rcnt + 16'd1;
          end
        end
        default: begin
          rstate <= REF_IDLE;
          rcnt   <= '0;
          stall  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Testbench for avalon_ram_responder.
//   Two instances are driven independently: READ_LATENCY=3 (default) and
//   READ_LATENCY=6. The second one makes the MAX_PENDING=4 limit reachable.
//   A reference model keeps a word array, a queue of outstanding reads with
//   due cycles, and the refresh schedule when WAIT_INJECT_EN is defined.
module tb_avalon_ram_responder;

  localparam int REF_P = 64;
  localparam int REF_C = 4;
  localparam int MAXP  = 4;

  typedef struct packed {
    bit        cs;
    bit        rd;
    bit        wr;
    bit [21:0] a;
    bit [15:0] d;
    bit [1:0]  be;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] addr [2];
  logic [1:0]  be_n [2];
  logic        cs   [2];
  logic        rd_n [2];
  logic        wr_n [2];
  logic [15:0] wd   [2];
  logic [15:0] rdata  [2];
  logic        rvalid [2];
  logic        wreq   [2];

  int checks   = 0;
  int failures = 0;

  // initiator op queues (a real request stays at the head until accepted)
  op_t q0[$];
  op_t q1[$];

  // reference model state
  int unsigned cyc = 0;
  int unsigned rel = 0;
  bit [15:0]   mm [2][4096];
  bit          kn [2][4096];
  int unsigned qdue [2][8];
  bit [15:0]   qd [2][8];
  bit          qk [2][8];
  int unsigned qh [2];
  int unsigned qn [2];
  bit [15:0]   last_d [2];
  bit          last_k [2];
  int unsigned vcnt [2];
  int unsigned racc [2];

  always #5 clk = ~clk;

  avalon_ram_responder #(.ADDR_BITS(12), .READ_LATENCY(3), .MAX_PENDING(4)) u_dut0 (
    .clk(clk), .sync_reset(rst), .av_address(addr[0]), .av_byteenable_n(be_n[0]),
    .av_chipselect(cs[0]), .av_writedata(wd[0]), .av_read_n(rd_n[0]), .av_write_n(wr_n[0]),
    .av_readdata(rdata[0]), .av_readdatavalid(rvalid[0]), .av_waitrequest(wreq[0]));

  avalon_ram_responder #(.ADDR_BITS(12), .READ_LATENCY(6), .MAX_PENDING(4)) u_dut1 (
    .clk(clk), .sync_reset(rst), .av_address(addr[1]), .av_byteenable_n(be_n[1]),
    .av_chipselect(cs[1]), .av_writedata(wd[1]), .av_read_n(rd_n[1]), .av_write_n(wr_n[1]),
    .av_readdata(rdata[1]), .av_readdatavalid(rvalid[1]), .av_waitrequest(wreq[1]));

  function automatic int unsigned lat(int k);
    return (k == 0) ? 3 : 6;
  endfunction

  function automatic bit stall_now();
`ifdef WAIT_INJECT_EN
    return !rst && ((rel % (REF_P + REF_C)) >= REF_P);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_wait(int k);
    return rst || (qn[k] == MAXP) || stall_now();
  endfunction

  function automatic bit exp_valid(int k);
    return !rst && (qn[k] > 0) && (qdue[k][qh[k]] == cyc);
  endfunction

  // {known, data}
  function automatic bit [16:0] exp_data(int k);
    if (rst) return {1'b1, 16'h0000};
    if (exp_valid(k)) return {qk[k][qh[k]], qd[k][qh[k]]};
    return {last_k[k], last_d[k]};
  endfunction

  function automatic bit drained();
    return (q0.size() == 0) && (q1.size() == 0) && (qn[0] == 0) && (qn[1] == 0);
  endfunction

  function automatic op_t mk(bit rd, bit wr, int unsigned a, int unsigned d, bit [1:0] be);
    op_t o;
    o.cs = 1'b1; o.rd = rd; o.wr = wr; o.a = 22'(a); o.d = 16'(d); o.be = be;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int unsigned t;
    t      = $urandom_range(0, 3);
    o.cs   = ($urandom_range(0, 9) != 0);
    o.rd   = (t == 0) || (t == 2);
    o.wr   = (t == 1) || (t == 2);
    o.a    = 22'($urandom_range(0, 15) | ($urandom_range(0, 3) << 12) | ($urandom_range(0, 1) << 21));
    o.d    = 16'($urandom);
    o.be   = 2'($urandom_range(0, 3));
    return o;
  endfunction

  task automatic drive();
    op_t o;
    for (int k = 0; k < 2; k++) begin
      o    = '0;
      o.a  = 22'($urandom);
      o.d  = 16'($urandom);
      if (k == 0 && q0.size() > 0) o = q0[0];
      if (k == 1 && q1.size() > 0) o = q1[0];
      cs[k]   = o.cs;
      rd_n[k] = !o.rd;
      wr_n[k] = !o.wr;
      addr[k] = o.a;
      wd[k]   = o.d;
      be_n[k] = o.be;
    end
  endtask

  // advance one clock and update the model with what was presented
  task automatic tick();
    bit v [2];
    bit acc [2];
    bit req [2];
    int unsigned i;
    int unsigned t;
    for (int k = 0; k < 2; k++) begin
      v[k]   = exp_valid(k);
      req[k] = cs[k] && (!rd_n[k] || !wr_n[k]);
      acc[k] = !rst && req[k] && !exp_wait(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      i = int'(addr[k][11:0]);
      if (rst) begin
        qn[k] = 0; qh[k] = 0; last_d[k] = '0; last_k[k] = 1'b1;
      end else begin
        if (v[k]) begin
          last_d[k] = qd[k][qh[k]];
          last_k[k] = qk[k][qh[k]];
          qh[k] = (qh[k] + 1) % 8;
          qn[k] = qn[k] - 1;
          vcnt[k]++;
        end
        if (acc[k] && !wr_n[k]) begin
          if (!be_n[k][0]) mm[k][i][7:0]  = wd[k][7:0];
          if (!be_n[k][1]) mm[k][i][15:8] = wd[k][15:8];
          if (be_n[k] == 2'b00) kn[k][i] = 1'b1;
        end else if (acc[k]) begin
          t = (qh[k] + qn[k]) % 8;
          qdue[k][t] = cyc + lat(k);
          qd[k][t]   = mm[k][i];
          qk[k][t]   = kn[k][i];
          qn[k]      = qn[k] + 1;
          racc[k]++;
        end
      end
      if (k == 0 && q0.size() > 0 && (acc[0] || !req[0])) q0.delete(0);
      if (k == 1 && q1.size() > 0 && (acc[1] || !req[1])) q1.delete(0);
    end
    rel = rst ? 0 : rel + 1;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (wreq[k] !== 1'b1) begin failures++; $display("FAIL reset_wait%0d got=%b exp=1", k, wreq[k]); end
        checks++;
        if (rvalid[k] !== 1'b0) begin failures++; $display("FAIL reset_valid%0d got=%b exp=0", k, rvalid[k]); end
        checks++;
        if (rdata[k] !== 16'h0000) begin failures++; $display("FAIL reset_data%0d got=%h exp=0000", k, rdata[k]); end
      end
      tick();
    end
    rst = 1'b0;
    drive();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (wreq[k] !== 1'b0) begin failures++; $display("FAIL post_reset_wait%0d got=%b exp=0", k, wreq[k]); end
    end
    tick();
  endtask

  task automatic test_directed();
    bit [15:0] exp_list[$];
    bit [16:0] ed;
    int n;
    exp_list = '{16'h1234, 16'h12CD, 16'h12CD, 16'h5555, 16'h5555};
    q0.push_back(mk(0, 1, 'h005, 'h1234, 2'b00));
    q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
    q0.push_back(mk(0, 1, 'h005, 'hABCD, 2'b10));
    q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
    q0.push_back(mk(0, 1, 'h005, 'hFFFF, 2'b11));
    q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
    q0.push_back(mk(0, 1, 'h005, 'h5555, 2'b00));
    q0.push_back(mk(1, 0, 'h0005, 0, 2'b00));
    q0.push_back(mk(1, 0, 'h1005, 0, 2'b00));
    n = 0;
    while (!drained()) begin
      if (n++ >= 200) begin failures++; $display("FAIL directed_timeout got=busy exp=drained"); break; end
      drive();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ed = exp_data(k);
        checks++;
        if (rvalid[k] !== exp_valid(k)) begin failures++; $display("FAIL directed_valid%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid[k], exp_valid(k)); end
        checks++;
        if (wreq[k] !== exp_wait(k)) begin failures++; $display("FAIL directed_wait%0d cyc=%0d got=%b exp=%b", k, cyc, wreq[k], exp_wait(k)); end
        if (ed[16]) begin
          checks++;
          if (rdata[k] !== ed[15:0]) begin failures++; $display("FAIL directed_data%0d cyc=%0d got=%h exp=%h", k, cyc, rdata[k], ed[15:0]); end
        end
      end
      if (rvalid[0] === 1'b1) begin
        checks++;
        if (exp_list.size() == 0) begin
          failures++; $display("FAIL directed_extra got=%h exp=none", rdata[0]);
        end else begin
          if (rdata[0] !== exp_list[0]) begin failures++; $display("FAIL directed_word got=%h exp=%h", rdata[0], exp_list[0]); end
          exp_list.delete(0);
        end
      end
      tick();
    end
    checks++;
    if (exp_list.size() != 0) begin failures++; $display("FAIL directed_count got=%0d exp=0 missing", exp_list.size()); end
  endtask

  task automatic test_back_to_back();
    bit [15:0] e0[$];
    bit [15:0] e1[$];
    bit [16:0] ed;
    int n;
    int w0;
    int w1;
    rst = 1'b1; drive(); tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(0, 1, 'h20 + i, 'hA000 + i * 'h111, 2'b00));
      q1.push_back(mk(0, 1, 'h20 + i, 'hB000 + i * 'h111, 2'b00));
    end
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(1, 0, 'h20 + i, 0, 2'b00));
      q1.push_back(mk(1, 0, 'h20 + i, 0, 2'b00));
      e0.push_back(16'('hA000 + i * 'h111));
      e1.push_back(16'('hB000 + i * 'h111));
    end
    n = 0; w0 = 0; w1 = 0;
    while (!drained()) begin
      if (n++ >= 200) begin failures++; $display("FAIL b2b_timeout got=busy exp=drained"); break; end
      drive();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ed = exp_data(k);
        checks++;
        if (rvalid[k] !== exp_valid(k)) begin failures++; $display("FAIL b2b_valid%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid[k], exp_valid(k)); end
        checks++;
        if (wreq[k] !== exp_wait(k)) begin failures++; $display("FAIL b2b_wait%0d cyc=%0d got=%b exp=%b", k, cyc, wreq[k], exp_wait(k)); end
        if (ed[16]) begin
          checks++;
          if (rdata[k] !== ed[15:0]) begin failures++; $display("FAIL b2b_data%0d cyc=%0d got=%h exp=%h", k, cyc, rdata[k], ed[15:0]); end
        end
      end
      if (wreq[0] === 1'b1) w0++;
      if (wreq[1] === 1'b1) w1++;
      if (rvalid[0] === 1'b1 && e0.size() > 0) begin
        checks++;
        if (rdata[0] !== e0[0]) begin failures++; $display("FAIL b2b_order0 got=%h exp=%h", rdata[0], e0[0]); end
        e0.delete(0);
      end
      if (rvalid[1] === 1'b1 && e1.size() > 0) begin
        checks++;
        if (rdata[1] !== e1[0]) begin failures++; $display("FAIL b2b_order1 got=%h exp=%h", rdata[1], e1[0]); end
        e1.delete(0);
      end
      tick();
    end
    checks++;
    if (e0.size() + e1.size() != 0) begin failures++; $display("FAIL b2b_lost got=%0d exp=0 words missing", e0.size() + e1.size()); end
    // latency 3 never reaches 4 outstanding; latency 6 stalls 3 cycles
    checks++;
    if (w0 != 0) begin failures++; $display("FAIL b2b_waitcount0 got=%0d exp=0", w0); end
    checks++;
    if (w1 != 3) begin failures++; $display("FAIL b2b_waitcount1 got=%0d exp=3", w1); end
  endtask

  task automatic test_reset_mid();
    bit [16:0] ed;
    int n;
    int fired;
    int after;
    int late;
    int unsigned base;
    base = racc[0];
    q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
    q0.push_back(mk(1, 0, 'h1005, 0, 2'b00));
    n = 0; fired = 0; after = 0; late = 0;
    while (!(fired == 2 && after >= 10)) begin
      if (n++ >= 100) begin failures++; $display("FAIL rmid_timeout got=busy exp=done"); break; end
      drive();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ed = exp_data(k);
        checks++;
        if (rvalid[k] !== exp_valid(k)) begin failures++; $display("FAIL rmid_valid%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid[k], exp_valid(k)); end
        checks++;
        if (wreq[k] !== exp_wait(k)) begin failures++; $display("FAIL rmid_wait%0d cyc=%0d got=%b exp=%b", k, cyc, wreq[k], exp_wait(k)); end
        if (ed[16]) begin
          checks++;
          if (rdata[k] !== ed[15:0]) begin failures++; $display("FAIL rmid_data%0d cyc=%0d got=%h exp=%h", k, cyc, rdata[k], ed[15:0]); end
        end
      end
      if (fired == 2 && rvalid[0] === 1'b1) late++;
      tick();
      if (fired == 2) after++;
      if (fired == 1) begin rst = 1'b0; fired = 2; end
      if (fired == 0 && racc[0] == base + 2) begin rst = 1'b1; fired = 1; end
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL rmid_stale_valid got=%0d exp=0", late); end
    // RAM survives reset: address 0x005 still holds 0x5555
    q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
    n = 0; late = 0;
    while (!drained()) begin
      if (n++ >= 50) begin failures++; $display("FAIL rmid_ram_timeout got=busy exp=drained"); break; end
      drive();
      @(negedge clk);
      if (rvalid[0] === 1'b1) begin
        late++;
        checks++;
        if (rdata[0] !== 16'h5555) begin failures++; $display("FAIL rmid_ram_kept got=%h exp=5555", rdata[0]); end
      end
      tick();
    end
    checks++;
    if (late != 1) begin failures++; $display("FAIL rmid_ram_count got=%0d exp=1", late); end
  endtask

  task automatic test_random();
    bit [16:0] ed;
    int n;
    n = 0;
    while (n < 600 && !(n >= 400 && drained())) begin
      if (n < 400) begin
        if (q0.size() == 0) q0.push_back(rnd_op());
        if (q1.size() == 0) q1.push_back(rnd_op());
      end
      n++;
      drive();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ed = exp_data(k);
        checks++;
        if (rvalid[k] !== exp_valid(k)) begin failures++; $display("FAIL rand_valid%0d cyc=%0d got=%b exp=%b", k, cyc, rvalid[k], exp_valid(k)); end
        checks++;
        if (wreq[k] !== exp_wait(k)) begin failures++; $display("FAIL rand_wait%0d cyc=%0d got=%b exp=%b", k, cyc, wreq[k], exp_wait(k)); end
        if (ed[16]) begin
          checks++;
          if (rdata[k] !== ed[15:0]) begin failures++; $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", k, cyc, rdata[k], ed[15:0]); end
        end
      end
      tick();
    end
    checks++;
    if (!drained()) begin failures++; $display("FAIL rand_drain got=busy exp=drained"); end
  endtask

`ifdef WAIT_INJECT_EN
  task automatic test_refresh();
    bit [16:0] ed;
    int whigh;
    int acc_rel;
    int unsigned before;
    rst = 1'b1; drive(); tick(); rst = 1'b0;
    whigh = 0; acc_rel = -1;
    while (rel < 90) begin
      if (rel == 64) q0.push_back(mk(1, 0, 'h005, 0, 2'b00));
      drive();
      @(negedge clk);
      ed = exp_data(0);
      checks++;
      if (wreq[0] !== exp_wait(0)) begin failures++; $display("FAIL refresh_wait rel=%0d got=%b exp=%b", rel, wreq[0], exp_wait(0)); end
      checks++;
      if (rvalid[0] !== exp_valid(0)) begin failures++; $display("FAIL refresh_valid rel=%0d got=%b exp=%b", rel, rvalid[0], exp_valid(0)); end
      if (ed[16]) begin
        checks++;
        if (rdata[0] !== ed[15:0]) begin failures++; $display("FAIL refresh_data rel=%0d got=%h exp=%h", rel, rdata[0], ed[15:0]); end
      end
      if (wreq[0] === 1'b1) whigh++;
      before = racc[0];
      tick();
      if (racc[0] != before) acc_rel = int'(rel) - 1;
    end
    checks++;
    if (whigh != REF_C) begin failures++; $display("FAIL refresh_stall_len got=%0d exp=%0d", whigh, REF_C); end
    checks++;
    if (acc_rel != REF_P + REF_C) begin failures++; $display("FAIL refresh_accept_rel got=%0d exp=%0d", acc_rel, REF_P + REF_C); end
  endtask
`endif

  initial begin
    for (int k = 0; k < 2; k++) begin
      qh[k] = 0; qn[k] = 0; last_d[k] = '0; last_k[k] = 1'b1; vcnt[k] = 0; racc[k] = 0;
    end
    drive();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef WAIT_INJECT_EN
    test_refresh();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
